eth_tx_frame_arbiter: RTL and testbench

Frame-level round-robin arbiter that shares the single 8-bit AXI-Stream TX input of the 1G RGMII MAC between `N_PORTS` upstream sources, e.g. the parser forward path and a host injection path. It grants one source per frame, holds the grant until `tlast`, and enforces a maximum frame length by truncating and flagging oversize frames. A registered output stage feeds the MAC's `tx_axis_*` directly.

---
 rtl/eth_pkg.sv | 14 +
 rtl/eth_tx_frame_arbiter_if.sv | 46 ++++
 rtl/rr_pick.sv | 29 ++
 rtl/eth_tx_frame_arbiter.sv | 149 ++++++++++++++
 tb/tb_eth_tx_frame_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet TX definitions: stream width, default frame limit and
// the frame arbiter state encoding.
package eth_pkg;

   localparam int ETH_AXIS_W        = 8;
   localparam int ETH_MAX_FRAME_LEN = 1514;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PASS = 2'd1,
      DROP = 2'd2
   } arb_state_t;

endpackage

// File: rtl/eth_tx_frame_arbiter_if.sv
// Bundle of the N source streams, the single MAC-facing stream and the
// arbiter status/debug signals.
interface eth_tx_frame_arbiter_if
   import eth_pkg::*;
#(
   parameter int N_PORTS = 2
);
   localparam int GW = $clog2(N_PORTS);

   // Every stream moves a beat only on a clock edge where valid and ready are
   // both high; a source holds data/last/user stable while valid && !ready,
   // and ready never depends combinationally on the same stream's valid.
   logic [ETH_AXIS_W*N_PORTS-1:0] s_axis_tdata;
   logic [N_PORTS-1:0]            s_axis_tvalid;
   logic [N_PORTS-1:0]            s_axis_tlast;
   logic [N_PORTS-1:0]            s_axis_tuser;
   logic [N_PORTS-1:0]            s_axis_tready;

   logic [ETH_AXIS_W-1:0]         m_axis_tdata;
   logic                          m_axis_tvalid;
   logic                          m_axis_tlast;
   logic                          m_axis_tuser;
   logic                          m_axis_tready;

   logic [GW-1:0]                 grant_idx;
   logic                          busy;
   logic                          oversize;
   arb_state_t                    dbg_state;

   modport slave (
      input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
      input  m_axis_tready,
      output s_axis_tready,
      output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
      output grant_idx, busy, oversize, dbg_state
   );

   modport master (
      output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
      output m_axis_tready,
      input  s_axis_tready,
      input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
      input  grant_idx, busy, oversize, dbg_state
   );

endinterface

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: the first set request scanning
// upward (with wrap) from the port after i_last wins.
module rr_pick #(
   parameter int N  = 2,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_last,
   output logic [IW-1:0] o_idx,
   output logic          o_valid
);

   logic [IW-1:0] w_cand;

   // Scan from the farthest offset down so the nearest requester overwrites last.
   always_comb begin
      o_idx   = '0;
      o_valid = 1'b0;
      w_cand  = '0;
      for (int k = N; k >= 1; k--) begin
         w_cand = IW'((int'(i_last) + k) % N);
         if (i_req[w_cand]) begin
            o_idx   = w_cand;
            o_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-level round-robin arbiter feeding the RGMII MAC TX stream; holds a
// grant for a whole frame and truncates frames longer than MAX_FRAME_LEN.
module eth_tx_frame_arbiter
   import eth_pkg::*;
#(
   parameter int N_PORTS       = 2,
   parameter int MAX_FRAME_LEN = ETH_MAX_FRAME_LEN
) (
   input  logic                  clk_125mhz,
   input  logic                  rst_n,
   eth_tx_frame_arbiter_if.slave bus
);

   localparam int GW = $clog2(N_PORTS);
   localparam int CW = $clog2(MAX_FRAME_LEN + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(MAX_FRAME_LEN - 1);
   localparam logic [GW-1:0] RST_LAST = GW'(N_PORTS - 1);

   arb_state_t            r_state;
   arb_state_t            w_next_state;
   logic [GW-1:0]         r_grant;
   logic [GW-1:0]         r_last_grant;
   logic [GW-1:0]         w_pick_idx;
   logic                  w_pick_valid;
   logic [CW-1:0]         r_byte_cnt;
   logic [ETH_AXIS_W-1:0] r_tdata;
   logic                  r_tvalid;
   logic                  r_tlast;
   logic                  r_tuser;
   logic                  r_oversize;
   logic [ETH_AXIS_W-1:0] w_sel_data;
   logic                  w_sel_valid;
   logic                  w_sel_last;
   logic                  w_sel_user;
   logic                  w_out_free;
   logic                  w_accept;
   logic                  w_at_max;
   logic [N_PORTS-1:0]    w_tready;

   rr_pick #(.N(N_PORTS)) u_pick (
      .i_req   (bus.s_axis_tvalid),
      .i_last  (r_last_grant),
      .o_idx   (w_pick_idx),
      .o_valid (w_pick_valid)
   );

   always_comb begin
      w_sel_data  = '0;
      w_sel_valid = 1'b0;
      w_sel_last  = 1'b0;
      w_sel_user  = 1'b0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (r_grant == GW'(i)) begin
            w_sel_data  = bus.s_axis_tdata[ETH_AXIS_W*i +: ETH_AXIS_W];
            w_sel_valid = bus.s_axis_tvalid[i];
            w_sel_last  = bus.s_axis_tlast[i];
            w_sel_user  = bus.s_axis_tuser[i];
         end
      end
   end

   assign w_out_free = !r_tvalid || bus.m_axis_tready;
   // Beat about to be accepted is byte number MAX_FRAME_LEN of the frame.
   assign w_at_max   = (r_byte_cnt == LAST_CNT);
   assign w_accept   = w_sel_valid && (|w_tready);

   always_ff @(posedge clk_125mhz or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: if (w_pick_valid) w_next_state = PASS;
         PASS: begin
            if (w_accept) begin
               if (w_sel_last)    w_next_state = IDLE;
               else if (w_at_max) w_next_state = DROP;
            end
         end
         DROP: if (w_accept && w_sel_last) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Ready depends only on state, grant and the output register, never on tvalid.
   always_comb begin
      w_tready = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (r_grant == GW'(i)) begin
            if (r_state == PASS)      w_tready[i] = w_out_free;
            else if (r_state == DROP) w_tready[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_125mhz or negedge rst_n) begin
      if (!rst_n) begin
         r_grant      <= '0;
         r_last_grant <= RST_LAST;
         r_byte_cnt   <= '0;
         r_tdata      <= '0;
         r_tvalid     <= 1'b0;
         r_tlast      <= 1'b0;
         r_tuser      <= 1'b0;
         r_oversize   <= 1'b0;
      end else begin
         r_oversize <= 1'b0;
         if (r_state == IDLE && w_pick_valid) begin
            r_grant    <= w_pick_idx;
            r_byte_cnt <= '0;
         end
         if (r_state != IDLE && w_accept && w_sel_last) begin
            r_last_grant <= r_grant;
         end
         if (r_state == PASS && w_accept) begin
            r_byte_cnt <= r_byte_cnt + CW'(1);
         end
         if (w_out_free) begin
            if (r_state == PASS && w_accept) begin
               r_tvalid   <= 1'b1;
               r_tdata    <= w_sel_data;
               r_tlast    <= w_sel_last | w_at_max;
               r_tuser    <= w_sel_last ? w_sel_user : w_at_max;
               r_oversize <= !w_sel_last && w_at_max;
            end else begin
               r_tvalid <= 1'b0;
               r_tlast  <= 1'b0;
               r_tuser  <= 1'b0;
            end
         end
      end
   end

   assign bus.s_axis_tready = w_tready;
   assign bus.m_axis_tdata  = r_tdata;
   assign bus.m_axis_tvalid = r_tvalid;
   assign bus.m_axis_tlast  = r_tlast;
   assign bus.m_axis_tuser  = r_tuser;
   assign bus.grant_idx     = r_grant;
   assign bus.busy          = (r_state != IDLE);
   assign bus.oversize      = r_oversize;
   assign bus.dbg_state     = r_state;

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Bench for eth_tx_frame_arbiter with a 16-byte frame limit: a frame-level
// round-robin model fills the expected queue, a monitor checks the MAC side.
module tb_eth_tx_frame_arbiter;
   import eth_pkg::*;

   localparam int N    = 2;
   localparam int MAXL = 16;
   localparam int BW   = 10;

   logic clk_125mhz = 1'b0;
   logic rst_n;
   always #4 clk_125mhz = ~clk_125mhz;

   eth_tx_frame_arbiter_if #(.N_PORTS(N)) bus ();

   eth_tx_frame_arbiter #(.N_PORTS(N), .MAX_FRAME_LEN(MAXL)) dut (
      .clk_125mhz (clk_125mhz),
      .rst_n      (rst_n),
      .bus        (bus)
   );

   logic [7:0] src_data  [N];
   logic       src_valid [N];
   logic       src_last  [N];
   logic       src_user  [N];
   logic       m_rdy;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         bus.s_axis_tdata[8*i +: 8] = src_data[i];
         bus.s_axis_tvalid[i]       = src_valid[i];
         bus.s_axis_tlast[i]        = src_last[i];
         bus.s_axis_tuser[i]        = src_user[i];
      end
   end
   assign bus.m_axis_tready = m_rdy;

   int n_tests = 0;
   int n_fail  = 0;
   logic [BW-1:0] exp_q[$];
   logic [7:0] fbytes [N][$];
   int         flen   [N][$];
   bit         fuser  [N][$];
   int  model_last = N - 1;
   int  ovs_exp, ovs_seen;
   bit  mon_en, gap_chk_en, bp_mode;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add_frame(input int p, input int len, input bit user);
      flen[p].push_back(len);
      fuser[p].push_back(user);
      for (int b = 0; b < len; b++) fbytes[p].push_back(8'($urandom_range(0, 255)));
   endtask

   // Reference: each finished frame hands the grant to the next port with frames
   // left; output is the frame clipped to MAXL, the clipped last byte flagged bad.
   task automatic build_expected();
      int fi[N];
      int off[N];
      int p, len, olen;
      bit any, lst, usr;
      for (int i = 0; i < N; i++) begin fi[i] = 0; off[i] = 0; end
      while (1) begin
         any = 0;
         p   = 0;
         for (int k = 1; k <= N; k++) begin
            int c;
            c = (model_last + k) % N;
            if (!any && fi[c] < flen[c].size()) begin any = 1; p = c; end
         end
         if (!any) break;
         len  = flen[p][fi[p]];
         olen = (len > MAXL) ? MAXL : len;
         for (int b = 0; b < olen; b++) begin
            lst = (b == olen - 1);
            usr = lst && ((len > MAXL) ? 1'b1 : fuser[p][fi[p]]);
            exp_q.push_back({usr, lst, fbytes[p][off[p] + b]});
         end
         if (len > MAXL) ovs_exp++;
         off[p] += len;
         fi[p]++;
         model_last = p;
      end
   endtask

   task automatic wait_hs(input int p);
      int t;
      t = 0;
      while (1) begin
         @(negedge clk_125mhz);
         if (bus.s_axis_tready[p]) break;
         t++;
         if (t > 3000) begin
            n_tests++;
            n_fail++;
            $display("FAIL hs_timeout port %0d: tready never rose", p);
            break;
         end
      end
      @(posedge clk_125mhz);
      #1;
   endtask

   task automatic run_port(input int p, input bit gaps);
      while (flen[p].size() != 0) begin
         int len;
         bit usr;
         len = flen[p].pop_front();
         usr = fuser[p].pop_front();
         for (int b = 0; b < len; b++) begin
            if (gaps && b > 0 && $urandom_range(0, 3) == 0) begin
               src_valid[p] = 1'b0;
               @(posedge clk_125mhz);
               #1;
            end
            src_valid[p] = 1'b1;
            src_data[p]  = fbytes[p].pop_front();
            src_last[p]  = (b == len - 1);
            src_user[p]  = (b == len - 1) ? usr : 1'($urandom_range(0, 1));
            wait_hs(p);
         end
         src_valid[p] = 1'b0;
         src_last[p]  = 1'b0;
         src_user[p]  = 1'b0;
      end
   endtask

   task automatic latency_check();
      int cyc;
      cyc = 0;
      while (cyc < 10) begin
         @(posedge clk_125mhz);
         cyc++;
         @(negedge clk_125mhz);
         if (bus.m_axis_tvalid) break;
      end
      check("first_byte_latency", cyc, 2);
   endtask

   task automatic run_phase(input bit gaps, input bit bp, input bit gapchk, input bit latchk);
      ovs_exp  = 0;
      ovs_seen = 0;
      build_expected();
      @(posedge clk_125mhz);
      #1;
      bp_mode    = bp;
      gap_chk_en = gapchk;
      if (latchk) fork latency_check(); join_none
      for (int i = 0; i < N; i++) begin
         automatic int p = i;
         fork run_port(p, gaps); join_none
      end
      wait fork;
      for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(negedge clk_125mhz);
      check("drain_left", exp_q.size(), 0);
      exp_q.delete();
      repeat (2) @(negedge clk_125mhz);
      check("oversize_pulses", ovs_seen, ovs_exp);
      check("busy_after_phase", int'(bus.busy), 0);
      gap_chk_en = 1'b0;
      bp_mode    = 1'b0;
   endtask

   initial begin : tready_drv
      m_rdy = 1'b1;
      forever begin
         @(posedge clk_125mhz);
         #1;
         m_rdy = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin : monitor
      logic [BW-1:0] got, held, expv;
      bit stall_prev, in_gap;
      int gap;
      stall_prev = 0;
      in_gap     = 0;
      gap        = 0;
      forever begin
         @(negedge clk_125mhz);
         if (rst_n && mon_en) begin
            got = {bus.m_axis_tuser, bus.m_axis_tlast, bus.m_axis_tdata};
            check("tready_onehot", int'($countones(bus.s_axis_tready) <= 1), 1);
            if (stall_prev) check("stall_hold", int'({bus.m_axis_tvalid, got}), int'({1'b1, held}));
            if (bus.oversize) begin
               check("oversize_align", int'({bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tuser}), 7);
               ovs_seen++;
            end
            if (bus.m_axis_tvalid) begin
               if (in_gap && gap_chk_en) check("frame_gap", gap, 1);
               in_gap = 0;
               if (m_rdy) begin
                  if (exp_q.size() == 0) begin
                     n_tests++;
                     n_fail++;
                     $display("FAIL beat_unexpected: got 0x%0h with empty expected queue", got);
                  end else begin
                     expv = exp_q.pop_front();
                     check("beat", int'(got), int'(expv));
                  end
                  if (bus.m_axis_tlast) begin
                     in_gap = gap_chk_en;
                     gap    = 0;
                  end
                  stall_prev = 0;
               end else begin
                  stall_prev = 1;
                  held       = got;
               end
            end else begin
               if (in_gap) gap++;
               stall_prev = 0;
            end
         end else begin
            stall_prev = 0;
            in_gap     = 0;
         end
      end
   end

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      rst_n      = 1'b0;
      mon_en     = 1'b0;
      gap_chk_en = 1'b0;
      bp_mode    = 1'b0;
      for (int i = 0; i < N; i++) begin
         src_data[i]  = '0;
         src_valid[i] = 1'b0;
         src_last[i]  = 1'b0;
         src_user[i]  = 1'b0;
      end
      repeat (3) @(posedge clk_125mhz);
      #1;
      check("rst_m_tvalid", int'(bus.m_axis_tvalid), 0);
      check("rst_m_tdata", int'(bus.m_axis_tdata), 0);
      check("rst_m_tlast", int'(bus.m_axis_tlast), 0);
      check("rst_m_tuser", int'(bus.m_axis_tuser), 0);
      check("rst_s_tready", int'(bus.s_axis_tready), 0);
      check("rst_grant_idx", int'(bus.grant_idx), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_oversize", int'(bus.oversize), 0);
      check("rst_state", int'(bus.dbg_state), int'(IDLE));
      rst_n = 1'b1;
      @(posedge clk_125mhz);
      #1;
      mon_en = 1'b1;

      // single source, first-byte latency
      add_frame(0, 14, 1'b0);
      run_phase(1'b0, 1'b0, 1'b0, 1'b1);

      // contention, back-to-back frames with the one-cycle bubble
      for (int f = 0; f < 3; f++) begin
         add_frame(0, 10, 1'b0);
         add_frame(1, 10, 1'b0);
      end
      run_phase(1'b0, 1'b0, 1'b1, 1'b0);

      // random backpressure on a long frame and a short one
      add_frame(0, 100, 1'b0);
      add_frame(1, 12, 1'b0);
      run_phase(1'b0, 1'b1, 1'b0, 1'b0);

      // length boundaries around the limit
      add_frame(0, 20, 1'b0);
      add_frame(0, MAXL, 1'b0);
      add_frame(1, MAXL + 1, 1'b0);
      add_frame(1, 1, 1'b0);
      run_phase(1'b0, 1'b0, 1'b0, 1'b0);

      // bad-frame flag passes through only on the last beat
      add_frame(1, 8, 1'b1);
      add_frame(0, MAXL, 1'b1);
      run_phase(1'b0, 1'b0, 1'b0, 1'b0);

      for (int r = 0; r < 3; r++) begin
         for (int f = 0; f < 4; f++) begin
            add_frame(0, $urandom_range(1, MAXL + 8), 1'($urandom_range(0, 1)));
            add_frame(1, $urandom_range(1, MAXL + 8), 1'($urandom_range(0, 1)));
         end
         run_phase(1'b1, 1'b1, 1'b0, 1'b0);
      end

      // reset in the middle of a 30-byte frame
      mon_en = 1'b0;
      @(posedge clk_125mhz);
      #1;
      for (int b = 0; b < 5; b++) begin
         src_valid[0] = 1'b1;
         src_data[0]  = 8'($urandom_range(0, 255));
         src_last[0]  = 1'b0;
         wait_hs(0);
      end
      rst_n = 1'b0;
      #1;
      check("midrst_m_tvalid", int'(bus.m_axis_tvalid), 0);
      check("midrst_m_tdata", int'(bus.m_axis_tdata), 0);
      check("midrst_s_tready", int'(bus.s_axis_tready), 0);
      check("midrst_busy", int'(bus.busy), 0);
      check("midrst_grant_idx", int'(bus.grant_idx), 0);
      src_valid[0] = 1'b0;
      repeat (2) @(posedge clk_125mhz);
      #1;
      rst_n = 1'b1;
      exp_q.delete();
      model_last = N - 1;
      @(posedge clk_125mhz);
      #1;
      mon_en = 1'b1;

      // after reset port 0 must win against port 1
      add_frame(1, 6, 1'b0);
      add_frame(0, 7, 1'b0);
      run_phase(1'b0, 1'b0, 1'b0, 1'b0);

      repeat (3) @(posedge clk_125mhz);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
